// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard front end: frame deserialiser with start/parity/stop checks, E0/F0 prefix decode,
// a DEPTH-entry key FIFO and a two-deep display history of accepted make codes.
module ps2_key_fifo #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2,
  parameter int KEEP_BREAKS    = 0
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       PS2_CLK,
  input  logic                       PS2_DATA,
  input  logic                       POP,
  output logic [7:0]                 KEY_CODE,
  output logic                       KEY_EXT,
  output logic                       KEY_BRK,
  output logic                       KEY_VALID,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic [7:0]                 LAST_CODE,
  output logic [7:0]                 PREV_CODE,
  output logic                       OVERFLOW,
  output logic                       FRAME_ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic                   ps2_clk_s, ps2_dat_s, fall;

  state_t                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   err, byte_ok;

  logic                   ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic                   is_prefix, is_make, code_push;

  logic [9:0]             mem_q [DEPTH];
  logic [AW-1:0]          rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]          count_q, count_d;
  logic                   full, pop_eff, wr_en, ovf_set;
  logic                   overflow_q, frame_err_q;
  logic [7:0]             last_q, prev_q;
  logic [9:0]             head;

  // Pins idle high, so the synchronisers reset to 1 to avoid a spurious edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], PS2_DATA};
      clk_prev_q <= ps2_clk_s;
    end
  end

  assign ps2_clk_s = clk_sync_q[SYNC_STAGES-1];
  assign ps2_dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall      = clk_prev_q & ~ps2_clk_s;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    err       = 1'b0;
    byte_ok   = 1'b0;
    tmo_d     = (state_q == IDLE || fall) ? '0 : tmo_q + TW'(1);
    case (state_q)
      IDLE: if (fall) begin
        if (!ps2_dat_s) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end else begin
          err = 1'b1;
        end
      end
      DATA: if (fall) begin
        shift_d   = {ps2_dat_s, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall) begin
        par_d   = ps2_dat_s;
        state_d = STOP;
      end
      STOP: if (fall) begin
        if (ps2_dat_s && (^{shift_q, par_q})) byte_ok = 1'b1;
        else                                   err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      tmo_d   = '0;
      err     = 1'b1;
    end
  end

  always_comb begin
    is_prefix  = (shift_q == 8'hE0) || (shift_q == 8'hF0);
    is_make    = byte_ok && !is_prefix && !brk_pend_q;
    code_push  = byte_ok && !is_prefix && (!brk_pend_q || (KEEP_BREAKS != 0));
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    if (err) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (byte_ok) begin
      if (shift_q == 8'hE0)      ext_pend_d = 1'b1;
      else if (shift_q == 8'hF0) brk_pend_d = 1'b1;
      else begin
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
  end

  // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
  assign full    = (count_q == CW'(DEPTH));
  assign pop_eff = POP && (count_q != '0);
  assign wr_en   = code_push && (!full || pop_eff);
  assign ovf_set = code_push && full && !pop_eff;
  assign count_d = count_q + CW'(wr_en) - CW'(pop_eff);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      last_q      <= '0;
      prev_q      <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      count_q     <= count_d;
      frame_err_q <= err;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= {brk_pend_q, ext_pend_q, shift_q};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_eff) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (ovf_set)      overflow_q <= 1'b1;
      else if (pop_eff) overflow_q <= 1'b0;
      if (is_make) begin
        prev_q <= last_q;
        last_q <= shift_q;
      end
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign KEY_VALID = (count_q != '0);
  assign KEY_CODE  = KEY_VALID ? head[7:0] : 8'h00;
  assign KEY_EXT   = KEY_VALID & head[8];
  assign KEY_BRK   = KEY_VALID & head[9];
  assign COUNT     = count_q;
  assign LAST_CODE = last_q;
  assign PREV_CODE = prev_q;
  assign OVERFLOW  = overflow_q;
  assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo: clean keys, prefix sequences, frame errors, overflow, timeout, reset.
module tb_ps2_key_fifo;

  logic       CLK = 1'b0;
  logic       RST_N, PS2_CLK, PS2_DATA, POP;
  logic [7:0] KEY_CODE, LAST_CODE, PREV_CODE;
  logic       KEY_EXT, KEY_BRK, KEY_VALID, OVERFLOW, FRAME_ERR;
  logic [2:0] COUNT;

  int vectors     = 0;
  int miscompares = 0;
  int ferr_cnt    = 0;
  int ferr_base;

  ps2_key_fifo #(
    .DEPTH(4), .TIMEOUT_CYCLES(50000), .SYNC_STAGES(2), .KEEP_BREAKS(0)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA), .POP(POP),
    .KEY_CODE(KEY_CODE), .KEY_EXT(KEY_EXT), .KEY_BRK(KEY_BRK), .KEY_VALID(KEY_VALID),
    .COUNT(COUNT), .LAST_CODE(LAST_CODE), .PREV_CODE(PREV_CODE),
    .OVERFLOW(OVERFLOW), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  // Counts cycles with FRAME_ERR high so single-cycle pulses are never missed.
  always @(posedge CLK) if (FRAME_ERR === 1'b1) ferr_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One PS/2 bit; optionally pulses POP during the cycle in which the falling edge is seen.
  task automatic ps2_bit(input logic b, input bit pop_on_edge);
    @(negedge CLK); PS2_DATA = b;
    repeat (3) @(negedge CLK);
    PS2_CLK = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (pop_on_edge && i == 1) POP = 1'b1;
      if (pop_on_edge && i == 2) POP = 1'b0;
    end
    PS2_CLK = 1'b1;
    repeat (8) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit pop_stop);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit((~^b) ^ bad_par, 1'b0);
    ps2_bit(~bad_stop, pop_stop);
    repeat (4) @(negedge CLK);
  endtask

  task automatic key(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_pop;
    @(negedge CLK); POP = 1'b1;
    @(negedge CLK); POP = 1'b0;
  endtask

  initial begin
    logic [7:0] drain [4];
    drain = '{8'h24, 8'h2D, 8'h33, 8'h3C};
    RST_N = 1'b0; PS2_CLK = 1'b1; PS2_DATA = 1'b1; POP = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_valid", KEY_VALID, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_code", KEY_CODE, 0);
    chk("rst_last", LAST_CODE, 0);
    chk("rst_ovf", OVERFLOW, 0);
    chk("rst_ferr", FRAME_ERR, 0);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);

    // Clean key
    key(8'h1C);
    chk("clean_valid", KEY_VALID, 1);
    chk("clean_code", KEY_CODE, 8'h1C);
    chk("clean_ext", KEY_EXT, 0);
    chk("clean_count", COUNT, 1);
    chk("clean_last", LAST_CODE, 8'h1C);
    do_pop;
    chk("clean_pop_valid", KEY_VALID, 0);

    // Make, break, extended make
    key(8'h1C); key(8'hF0); key(8'h1C); key(8'hE0); key(8'h75);
    chk("seq_count", COUNT, 2);
    chk("seq_head", KEY_CODE, 8'h1C);
    chk("seq_head_ext", KEY_EXT, 0);
    chk("seq_last", LAST_CODE, 8'h75);
    chk("seq_prev", PREV_CODE, 8'h1C);
    do_pop;
    chk("seq_head2", KEY_CODE, 8'h75);
    chk("seq_head2_ext", KEY_EXT, 1);
    chk("seq_head2_brk", KEY_BRK, 0);
    do_pop;
    chk("seq_empty", COUNT, 0);

    // Frame errors
    ferr_base = ferr_cnt;
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    chk("par_ferr", ferr_cnt - ferr_base, 1);
    chk("par_count", COUNT, 0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    chk("stop_ferr", ferr_cnt - ferr_base, 2);
    chk("stop_count", COUNT, 0);
    key(8'h32);
    chk("good_count", COUNT, 1);
    chk("good_code", KEY_CODE, 8'h32);
    chk("good_ferr", ferr_cnt - ferr_base, 2);
    do_pop;

    // Overflow
    key(8'h15); key(8'h1D); key(8'h24); key(8'h2D);
    chk("full_ovf", OVERFLOW, 0);
    key(8'h2C);
    chk("ovf_set", OVERFLOW, 1);
    chk("ovf_count", COUNT, 4);
    chk("ovf_head", KEY_CODE, 8'h15);
    chk("ovf_last", LAST_CODE, 8'h2C);
    chk("ovf_prev", PREV_CODE, 8'h2D);
    do_pop;
    chk("ovf_clr", OVERFLOW, 0);
    chk("ovf_head2", KEY_CODE, 8'h1D);
    chk("ovf_count2", COUNT, 3);
    key(8'h33);
    chk("refill_count", COUNT, 4);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    chk("pushpop_count", COUNT, 4);
    chk("pushpop_ovf", OVERFLOW, 0);
    chk("pushpop_head", KEY_CODE, 8'h24);
    for (int i = 0; i < 4; i++) begin
      chk("drain_code", KEY_CODE, drain[i]);
      do_pop;
    end
    chk("drain_empty", KEY_VALID, 0);

    // Timeout, also clearing a pending E0
    key(8'hE0);
    ferr_base = ferr_cnt;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
    repeat (49900) @(negedge CLK);
    chk("tmo_early", ferr_cnt - ferr_base, 0);
    repeat (150) @(negedge CLK);
    chk("tmo_ferr", ferr_cnt - ferr_base, 1);
    chk("tmo_count", COUNT, 0);
    key(8'h1C);
    chk("tmo_after_count", COUNT, 1);
    chk("tmo_after_code", KEY_CODE, 8'h1C);
    chk("tmo_after_ext", KEY_EXT, 0);
    chk("tmo_after_ferr", ferr_cnt - ferr_base, 1);

    // Reset in the middle of a frame
    ferr_base = ferr_cnt;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1, 1'b0);
    @(negedge CLK); RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    chk("mrst_valid", KEY_VALID, 0);
    chk("mrst_count", COUNT, 0);
    chk("mrst_code", KEY_CODE, 0);
    chk("mrst_last", LAST_CODE, 0);
    chk("mrst_prev", PREV_CODE, 0);
    chk("mrst_ovf", OVERFLOW, 0);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    key(8'h1C);
    chk("mrst_after_count", COUNT, 1);
    chk("mrst_after_code", KEY_CODE, 8'h1C);
    chk("mrst_after_last", LAST_CODE, 8'h1C);
    chk("mrst_ferr", ferr_cnt - ferr_base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_key_fifo.md
Name: ps2_key_fifo

Overview:
- Parametrised PS/2 keyboard front end. Replaces the single "last valid key" latch.
- Deserialises PS/2 device-to-host frames and checks start, odd parity and stop bits.
- Decodes the E0 (extended) and F0 (break) prefixes.
- Queues make codes in a DEPTH-entry FIFO. Also keeps the last two accepted codes for direct display.
- Sits between the PS2_CLK/PS2_DATA pins and the CPU/peripheral side that pops keys.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 50000, CLK cycles without a PS2_CLK falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- SYNC_STAGES, 2, synchroniser flops on PS2_CLK and PS2_DATA; ≥2.
- KEEP_BREAKS, 0, 1 = also queue break codes, with KEY_BRK=1.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- PS2_CLK  in  1  keyboard clock pin, asynchronous
- PS2_DATA  in  1  keyboard data pin, asynchronous
- POP  in  1  consume FIFO head; ignored when empty
- KEY_CODE  out  8  scan code at FIFO head
- KEY_EXT  out  1  head code was E0-prefixed
- KEY_BRK  out  1  head code was F0-prefixed (only possible when KEEP_BREAKS=1)
- KEY_VALID  out  1  FIFO not empty
- COUNT  out  $clog2(DEPTH)+1  FIFO occupancy
- LAST_CODE  out  8  most recent accepted make code
- PREV_CODE  out  8  make code accepted before LAST_CODE
- OVERFLOW  out  1  sticky: a code was dropped because the FIFO was full
- FRAME_ERR  out  1  one-cycle pulse on a bad start, parity or stop bit, or on timeout

Behaviour:
- Reset (RST_N low, asynchronous): all outputs 0, FIFO empty, FSM in IDLE, prefix flags clear, synchronisers loaded with 1.
- Input sampling:
  - Both pins pass through SYNC_STAGES flops.
  - A falling edge is detected as sync_prev=1 and sync=0; one event per edge.
  - Data is sampled on the same cycle the edge is detected.
- Frame FSM:
  - IDLE: on an edge, data=0 → DATA with bit count 0; data=1 → FRAME_ERR, stay in IDLE.
  - DATA: shift bits in LSB first; after 8 bits → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: on an edge, stop=1 and odd parity over data+parity → byte accepted; otherwise FRAME_ERR. Either way → IDLE.
- Timeout:
  - Applies in any state other than IDLE.
  - A cycle counter resets on every edge. On reaching TIMEOUT_CYCLES: → IDLE, FRAME_ERR, prefix flags cleared.
- Prefix handling on an accepted byte:
  - 0xE0 sets ext_pend.
  - 0xF0 sets brk_pend.
  - Any other byte is a code: a make code when brk_pend=0, a break code when brk_pend=1. Push {code, ext_pend, brk_pend} if it is a make code, or if KEEP_BREAKS=1. Then clear both flags.
  - Break codes are never pushed when KEEP_BREAKS=0.
  - A FRAME_ERR clears both flags.
- LAST/PREV update: on each accepted make code, PREV_CODE←LAST_CODE and LAST_CODE←code. Updated even when the FIFO is full.
- Push timing: the push happens on the clock edge that ends the cycle where the stop bit is detected. KEY_VALID and COUNT reflect the push from the next cycle.
- FIFO:
  - Head registered. Circular pointers wrap modulo DEPTH.
  - POP with KEY_VALID=1 advances the head. The next entry appears on the following cycle.
  - Push when COUNT=DEPTH with no POP: the new code is dropped, FIFO unchanged, OVERFLOW←1.
  - Push and POP in the same cycle: both take effect, COUNT unchanged, no overflow, even when full.
  - POP when empty: no effect.
- OVERFLOW clears on the first POP after it was set (ordinary FIFO operation), or on reset.
- Reset mid-frame: the partial frame is discarded; no push, no FRAME_ERR.

Test Plan:
- Clean key: frame 0x1C (data LSB-first 0,0,1,1,1,0,0,0; parity 0; stop 1) → KEY_VALID=1, KEY_CODE=0x1C, KEY_EXT=0, COUNT=1, LAST_CODE=0x1C; POP → KEY_VALID=0 next cycle.
- Sequences: 0x1C, F0, 0x1C, E0, 0x75 with KEEP_BREAKS=0 → FIFO holds 0x1C (EXT=0) then 0x75 (EXT=1); COUNT=2; LAST_CODE=0x75, PREV_CODE=0x1C.
- Errors: 0x1C with parity 1 → FRAME_ERR pulse, COUNT=0; then 0x32 sent with stop bit 0 → FRAME_ERR, nothing pushed; then a valid 0x32 → pushed.
- Overflow: DEPTH=4, push 0x15, 0x1D, 0x24, 0x2D, 0x2C → OVERFLOW=1, COUNT=4, head 0x15, LAST_CODE=0x2C; one POP → OVERFLOW=0, head 0x1D; push while full with POP asserted the same cycle → COUNT stays 4.
- Timeout: send start plus 4 data bits, idle 50001 cycles → FRAME_ERR, FSM in IDLE; a following valid 0x1C frame → received correctly.
- Reset: RST_N low after 6 bits of a frame → all outputs 0; after release, a full 0x1C frame → accepted.
